// File: rtl/jpeg_block_fetcher.sv
// Purpose: fetches one 8x8 pixel block (16 x 32-bit words) from data memory and streams it out as bytes.
// Latency: 6 cycles per word at best (READ, CAPTURE, 4 x EMIT), so 96 cycles from first READ to DONE.
// Backpressure: out_ready low holds the current byte stable and extends EMIT; no ready->valid comb path.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, base_addr           1-cycle start request (IDLE only) and word base address
//   busy, done                 busy from accepted start through the done pulse; done = 1-cycle pulse
//   mem_*                      Avalon-MM read master to the single-port data memory (1-cycle latency)
//   out_data/valid/ready/last  byte stream, little-endian within each word, last on byte 63
module jpeg_block_fetcher #(
  parameter int ADDR_W      = 11,
  parameter int BLOCK_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       word_buf_q, word_buf_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_chipselect_q, mem_chipselect_d;

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    mem_address_d    = mem_address_q;
    idx_d            = idx_q;
    byte_d           = byte_q;
    word_buf_d       = word_buf_q;
    out_data_d       = out_data_q;
    out_valid_d      = out_valid_q;
    out_last_d       = out_last_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    mem_chipselect_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d           = base_addr;
          idx_d            = '0;
          mem_address_d    = base_addr;
          mem_chipselect_d = 1'b1;
          busy_d           = 1'b1;
          state_d          = S_READ;
        end
      end
      S_READ: begin
        // Memory returns the word during the next cycle.
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        word_buf_d  = mem_readdata;
        byte_d      = 2'd0;
        out_data_d  = mem_readdata[7:0];
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (byte_q == 2'd3) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              idx_d            = idx_q + 1'b1;
              // Address arithmetic wraps naturally at ADDR_W bits.
              mem_address_d    = base_q + ADDR_W'(idx_q) + ADDR_W'(1);
              mem_chipselect_d = 1'b1;
              state_d          = S_READ;
            end
          end else begin
            byte_d     = byte_q + 2'd1;
            out_data_d = word_buf_q[{byte_q + 2'd1, 3'b000} +: 8];
            out_last_d = (idx_q == LAST_IDX) && (byte_q == 2'd2);
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      base_q           <= '0;
      mem_address_q    <= '0;
      idx_q            <= '0;
      byte_q           <= '0;
      word_buf_q       <= '0;
      out_data_q       <= '0;
      out_valid_q      <= 1'b0;
      out_last_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      mem_chipselect_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      mem_address_q    <= mem_address_d;
      idx_q            <= idx_d;
      byte_q           <= byte_d;
      word_buf_q       <= word_buf_d;
      out_data_q       <= out_data_d;
      out_valid_q      <= out_valid_d;
      out_last_q       <= out_last_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      mem_chipselect_q <= mem_chipselect_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_address    = mem_address_q;
  assign mem_chipselect = mem_chipselect_q;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'b1111;
  assign mem_clken      = 1'b1;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;

endmodule

// File: tb/tb_jpeg_block_fetcher.sv
// Purpose: directed self-checking bench for jpeg_block_fetcher with a 1-cycle-latency memory model.
// Latency: checks 96 cycles first READ -> DONE and done one cycle after the last byte.
// Backpressure: exercises pseudo-random out_ready and checks held data during stalls.
module tb_jpeg_block_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] base_addr;
  logic        busy;
  logic        done;
  logic [10:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  // Single-port memory: address registered on the edge, q visible the following cycle.
  always @(posedge clk) mem_readdata <= mem[mem_address];

  jpeg_block_fetcher #(.ADDR_W(11), .BLOCK_WORDS(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [10:0] base, input int k);
    logic [31:0] w;
    w = mem[11'(base + k / 4)];
    return w[(k % 4) * 8 +: 8];
  endfunction

  // Starts a block at the current negedge and checks the whole transaction.
  task automatic run_block(input logic [10:0] base, input bit toggle, input bit restart,
                           input string nm);
    int nbytes, cs_cnt, done_cnt, done_cyc, first_cs, last_xfer, cs_at;
    int const_err, addr_err, cap_err, stall_err, busy_err;
    bit was_stall;
    logic [7:0] held;
    nbytes = 0; cs_cnt = 0; done_cnt = 0; done_cyc = -1; first_cs = -1; last_xfer = -1;
    cs_at = -10; const_err = 0; addr_err = 0; cap_err = 0; stall_err = 0; busy_err = 0;
    was_stall = 1'b0; held = 8'h00;
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      out_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = restart && (cyc == 10);
      base_addr = (restart && cyc == 10) ? 11'h200 : base;
      if (mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_clken !== 1'b1) const_err++;
      if (cyc == cs_at + 1 && (mem_chipselect || out_valid)) cap_err++;
      if (cyc == cs_at + 2 && !out_valid) cap_err++;
      if (mem_chipselect) begin
        if (first_cs < 0) first_cs = cyc;
        if (mem_address !== 11'(base + cs_cnt)) addr_err++;
        cs_cnt++;
        cs_at = cyc;
      end
      if (was_stall && (!out_valid || out_data !== held)) stall_err++;
      was_stall = out_valid && !out_ready;
      held = out_data;
      if (done_cnt == 0 && busy !== 1'b1) busy_err++;
      if (out_valid && out_ready) begin
        check({nm, "_byte"}, 32'(out_data), 32'(exp_byte(base, nbytes)));
        check({nm, "_last"}, 32'(out_last), 32'(nbytes == 63));
        nbytes++;
        last_xfer = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1 && busy !== 1'b0) busy_err++;
      if (done_cyc >= 0 && cyc == done_cyc + 4) break;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({nm, "_chipselects"}, cs_cnt, 16);
    check({nm, "_bytes"}, nbytes, 64);
    check({nm, "_done_pulses"}, done_cnt, 1);
    check({nm, "_done_after_last"}, done_cyc - last_xfer, 1);
    check({nm, "_const_outputs_err"}, const_err, 0);
    check({nm, "_addr_err"}, addr_err, 0);
    check({nm, "_capture_seq_err"}, cap_err, 0);
    check({nm, "_stall_hold_err"}, stall_err, 0);
    check({nm, "_busy_err"}, busy_err, 0);
    if (!toggle) check({nm, "_cycles_read_to_done"}, done_cyc - first_cs, 96);
  endtask

  initial begin
    int csn, dn;
    bit got_w5;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h9E3779B9 * (i + 1);
    for (int i = 0; i < 16; i++) mem[11'h100 + i] = 32'h03020100 + 32'h04040404 * i;

    reset = 1'b1; start = 1'b0; base_addr = 11'h000; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_chipselect", 32'(mem_chipselect), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_mem_address", 32'(mem_address), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    run_block(11'h100, 1'b0, 1'b0, "t1_basic");
    repeat (2) @(negedge clk);
    run_block(11'h100, 1'b1, 1'b0, "t2_stall");
    repeat (2) @(negedge clk);
    run_block(11'h7F8, 1'b0, 1'b0, "t3_wrap");
    repeat (2) @(negedge clk);
    run_block(11'h100, 1'b0, 1'b1, "t4_restart");
    repeat (2) @(negedge clk);

    // Reset while emitting word 5.
    start = 1'b1; base_addr = 11'h100;
    @(negedge clk);
    start = 1'b0;
    csn = 0; got_w5 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (mem_chipselect) csn++;
      if (csn == 6 && out_valid) begin
        got_w5 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t5_reach_word5", 32'(got_w5), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(done), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_out_last", 32'(out_last), 0);
    check("t5_chipselect", 32'(mem_chipselect), 0);
    check("t5_out_data", 32'(out_data), 0);
    check("t5_mem_address", 32'(mem_address), 0);
    reset = 1'b0;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy || out_valid || mem_chipselect) dn++;
    end
    check("t5_quiet_after_reset", dn, 0);
    run_block(11'h040, 1'b0, 1'b0, "t5_after");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
